// File: rtl/rx_block_fifo.sv
// Receive-side block assembler plus first-word-fall-through block FIFO.
// Bytes are packed MSB-first into BLOCK_BYTES-wide blocks. Completed blocks are
// queued for the control unit, which pops them with rcv_deq.
module rx_block_fifo #(
  parameter int unsigned BLOCK_BYTES = 8,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  input  logic                         flush,
  input  logic                         rcv_deq,
  output logic [8*BLOCK_BYTES-1:0]     block_out,
  output logic                         emptyRx,
  output logic                         fullRx,
  output logic [$clog2(DEPTH):0]       blk_count,
  output logic [$clog2(BLOCK_BYTES)-1:0] byte_idx,
  output logic                         overrun
);

  localparam int unsigned BlkW = 8 * BLOCK_BYTES;
  localparam int unsigned IdxW = $clog2(BLOCK_BYTES);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_BYTES - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  // Only the bytes before the final one need holding; the final byte is
  // taken straight from byte_in when the block completes.
  logic [BlkW-9:0] sreg_q, sreg_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [BlkW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic            overrun_q, overrun_d;

  logic [BlkW-1:0] blk_new;
  logic            complete, push, pop;

  // Next-state logic: flush wins over byte and pop; a pop makes room for a
  // push in the same cycle, but an empty FIFO can never be popped.
  always_comb begin
    blk_new   = {sreg_q, byte_in};
    complete  = byte_valid && (idx_q == LastIdx);
    pop       = rcv_deq && (cnt_q != '0);
    push      = complete && ((cnt_q != FullCnt) || pop);
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    if (flush) begin
      sreg_d    = '0;
      idx_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (byte_valid) begin
        sreg_d = blk_new[BlkW-9:0];
        idx_d  = complete ? '0 : idx_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (complete && !push) overrun_d = 1'b1;
    end
  end

  // State registers, storage write and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q    <= '0;
      idx_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      empty_q   <= (cnt_d == '0);
      full_q    <= (cnt_d == FullCnt);
      if (!flush && push) mem_q[wr_ptr_q] <= blk_new;
    end
  end

  assign block_out = mem_q[rd_ptr_q];
  assign emptyRx   = empty_q;
  assign fullRx    = full_q;
  assign blk_count = cnt_q;
  assign byte_idx  = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_block_fifo.sv
// Self-checking bench for rx_block_fifo: directed scenarios plus a random
// phase, all compared against a queue-based reference model every cycle.
module tb_rx_block_fifo;

  localparam int unsigned BB = 8;
  localparam int unsigned DP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        flush = 1'b0;
  logic        rcv_deq = 1'b0;
  logic [63:0] block_out;
  logic        emptyRx;
  logic        fullRx;
  logic [2:0]  blk_count;
  logic [2:0]  byte_idx;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued blocks, bytes of the partial block, sticky flag.
  logic [63:0] mq[$];
  logic [7:0]  part[$];
  bit          m_ovr = 1'b0;

  rx_block_fifo #(.BLOCK_BYTES(BB), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .flush      (flush),
    .rcv_deq    (rcv_deq),
    .block_out  (block_out),
    .emptyRx    (emptyRx),
    .fullRx     (fullRx),
    .blk_count  (blk_count),
    .byte_idx   (byte_idx),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int n);
    logic [63:0] b = '0;
    for (int k = 0; k < 8; k++) b = {b[55:0], 8'((n * 16 + k) & 8'hFF)};
    return b;
  endfunction

  task automatic model_update(input logic rst, input logic bv, input logic [7:0] b,
                              input logic fl, input logic dq);
    logic [63:0] blk;
    bit          popped;
    if (rst || fl) begin
      mq.delete();
      part.delete();
      m_ovr = 1'b0;
    end else begin
      popped = dq && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (bv) begin
        part.push_back(b);
        if (part.size() == BB) begin
          blk = '0;
          foreach (part[i]) blk = {blk[55:0], part[i]};
          part.delete();
          if (mq.size() < DP) mq.push_back(blk);
          else m_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("emptyRx", 64'(emptyRx), 64'(mq.size() == 0));
    check("fullRx", 64'(fullRx), 64'(mq.size() == DP));
    check("blk_count", 64'(blk_count), 64'(mq.size()));
    check("byte_idx", 64'(byte_idx), 64'(part.size()));
    check("overrun", 64'(overrun), 64'(m_ovr));
    if (mq.size() > 0) check("block_out", block_out, mq[0]);
  endtask

  task automatic step(input logic rst, input logic bv, input logic [7:0] b,
                      input logic fl, input logic dq);
    reset = rst; byte_valid = bv; byte_in = b; flush = fl; rcv_deq = dq;
    @(posedge clk);
    model_update(rst, bv, b, fl, dq);
    #1;
    check_all();
  endtask

  task automatic send_block(input logic [63:0] blk, input logic dq_last);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, blk[63-8*k -: 8], 1'b0, dq_last && (k == 7));
  endtask

  task automatic idle(input logic dq);
    step(1'b0, 1'b0, 8'h00, 1'b0, dq);
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_block_out", block_out, 64'h0);
    check("rst_empty", 64'(emptyRx), 64'h1);
    check("rst_full", 64'(fullRx), 64'h0);

    // 1: single block
    send_block(64'h0102030405060708, 1'b0);
    check("t1_block", block_out, 64'h0102030405060708);
    check("t1_count", 64'(blk_count), 64'd1);
    check("t1_empty", 64'(emptyRx), 64'd0);
    idle(1'b1);
    check("t1_empty_after_pop", 64'(emptyRx), 64'd1);

    // 2: fill and overrun
    for (int n = 1; n <= 5; n++) begin
      send_block(mk(n), 1'b0);
      if (n == 4) check("t2_full", 64'(fullRx), 64'd1);
    end
    check("t2_overrun", 64'(overrun), 64'd1);
    check("t2_count", 64'(blk_count), 64'd4);
    for (int n = 1; n <= 4; n++) begin
      check("t2_pop_order", block_out, mk(n));
      idle(1'b1);
    end
    check("t2_empty", 64'(emptyRx), 64'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t2_flush_clears_ovr", 64'(overrun), 64'd0);

    // 3: full with push and pop together
    for (int n = 1; n <= 4; n++) send_block(mk(n), 1'b0);
    send_block(mk(5), 1'b1);
    check("t3_count", 64'(blk_count), 64'd4);
    check("t3_overrun", 64'(overrun), 64'd0);
    for (int n = 2; n <= 5; n++) begin
      check("t3_pop_order", block_out, mk(n));
      idle(1'b1);
    end

    // 4: underflow then streaming with wrap
    idle(1'b1);
    check("t4_underflow_count", 64'(blk_count), 64'd0);
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 0 && n > 0) check("t4_stream", block_out, mk(n - 1));
        step(1'b0, 1'b1, 8'((n * 16 + k) & 8'hFF), 1'b0, (k == 0) && (n > 0));
      end
    end
    check("t4_stream_last", block_out, mk(9));
    idle(1'b1);
    check("t4_overrun", 64'(overrun), 64'd0);

    // 5: flush mid-block
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    check("t5_idx", 64'(byte_idx), 64'd0);
    check("t5_empty", 64'(emptyRx), 64'd1);
    send_block(64'hA0A1A2A3A4A5A6A7, 1'b0);
    check("t5_block", block_out, 64'hA0A1A2A3A4A5A6A7);
    idle(1'b1);

    // 6: reset mid-operation
    send_block(mk(6), 1'b0);
    send_block(mk(7), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_block_out", block_out, 64'h0);
    check("t6_count", 64'(blk_count), 64'd0);
    check("t6_idx", 64'(byte_idx), 64'd0);
    check("t6_empty", 64'(emptyRx), 64'd1);
    send_block(mk(8), 1'b0);
    check("t6_fresh_block", block_out, mk(8));

    // Random phase against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 8'($urandom),
           ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
